regfile_op_sequencer: RTL and testbench



---
 rtl/regseq_pkg.sv | 33 +++
 rtl/seq_alu.sv | 56 +++++
 rtl/regfile_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regseq_pkg.sv
// ============================================================================
// Module  : regseq_pkg
// Purpose : Shared opcode/state encodings and address width for the
//           register-file operation sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regseq_pkg;

    localparam int ADDR_W = 2;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_LDI  = 3'b101,
        OP_ADDI = 3'b110,
        OP_MOV  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module  : seq_alu
// Purpose : Combinational ALU for the sequencer; carry is the ADD/ADDI
//           carry-out or the SUB borrow, zero for all other opcodes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import regseq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_wide;

    always_comb begin
        w_wide   = '0;
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_wide   = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_wide[WIDTH-1:0];
                o_carry  = w_wide[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                w_wide   = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_wide[WIDTH-1:0];
                o_carry  = w_wide[WIDTH];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_LDI:  o_result = i_imm;
            OP_ADDI: begin
                w_wide   = {1'b0, i_a} + {1'b0, i_imm};
                o_result = w_wide[WIDTH-1:0];
                o_carry  = w_wide[WIDTH];
            end
            OP_MOV:  o_result = i_a;
            default: o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/regfile_op_sequencer.sv
// ============================================================================
// Module  : regfile_op_sequencer
// Purpose : Four-phase (IDLE/READ/EXEC/WRITE) instruction sequencer driving a
//           4-entry register file. Optional flags enabled by SEQ_FLAGS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_op_sequencer
    import regseq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [WIDTH-1:0]  instr_imm,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr_input,
    output logic [ADDR_W-1:0] rf_addr_out1,
    output logic [ADDR_W-1:0] rf_addr_out2,
    output logic [WIDTH-1:0]  rf_data,
    input  logic [WIDTH-1:0]  rf_out1,
    input  logic [WIDTH-1:0]  rf_out2,
    output logic              done,
    output logic [WIDTH-1:0]  result
`ifdef SEQ_FLAGS_EN
    ,
    output logic              zero_flag,
    output logic              carry_flag
`endif
);

    state_e            r_state;
    state_e            w_state_next;

    op_e               r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [WIDTH-1:0]  r_imm;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_result;

    logic [WIDTH-1:0]  w_alu_result;
`ifdef SEQ_FLAGS_EN
    logic              w_alu_carry;
    logic              r_zero;
    logic              r_carry;
`else
    logic              w_unused_carry;
`endif

    seq_alu #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
        .o_result (w_alu_result),
`ifdef SEQ_FLAGS_EN
        .o_carry  (w_alu_carry)
`else
        .o_carry  (w_unused_carry)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs decode straight from state so reset drops rf_we at once.
    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        rf_we        = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_next = S_READ;
                end
            end
            S_READ:  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WRITE;
            S_WRITE: begin
                rf_we        = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_ADD;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
`ifdef SEQ_FLAGS_EN
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op  <= op_e'(instr_op);
                        r_rd  <= instr_rd;
                        r_rs1 <= instr_rs1;
                        r_rs2 <= instr_rs2;
                        r_imm <= instr_imm;
                    end
                end
                S_READ: begin
                    r_a <= rf_out1;
                    r_b <= rf_out2;
                end
                S_EXEC: begin
                    r_result <= w_alu_result;
`ifdef SEQ_FLAGS_EN
                    r_zero   <= (w_alu_result == '0);
                    r_carry  <= w_alu_carry;
`endif
                end
                default: ;
            endcase
        end
    end

    // Read addresses come from the latched fields, so they hold outside READ.
    assign rf_addr_out1  = r_rs1;
    assign rf_addr_out2  = r_rs2;
    assign rf_addr_input = r_rd;
    assign rf_data       = r_result;
    assign result        = r_result;
`ifdef SEQ_FLAGS_EN
    assign zero_flag     = r_zero;
    assign carry_flag    = r_carry;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_op_sequencer.sv
// ============================================================================
// Module  : tb_regfile_op_sequencer
// Purpose : Bench for regfile_op_sequencer with a behavioural register file
//           and a timeline model of each instruction (SEQ_FLAGS_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_op_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [2:0]       instr_op = '0;
    logic [1:0]       instr_rd = '0;
    logic [1:0]       instr_rs1 = '0;
    logic [1:0]       instr_rs2 = '0;
    logic [WIDTH-1:0] instr_imm = '0;
    logic             rf_we;
    logic [1:0]       rf_addr_input;
    logic [1:0]       rf_addr_out1;
    logic [1:0]       rf_addr_out2;
    logic [WIDTH-1:0] rf_data;
    logic [WIDTH-1:0] rf_out1;
    logic [WIDTH-1:0] rf_out2;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef SEQ_FLAGS_EN
    logic             zero_flag;
    logic             carry_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs1     (instr_rs1),
        .instr_rs2     (instr_rs2),
        .instr_imm     (instr_imm),
        .rf_we         (rf_we),
        .rf_addr_input (rf_addr_input),
        .rf_addr_out1  (rf_addr_out1),
        .rf_addr_out2  (rf_addr_out2),
        .rf_data       (rf_data),
        .rf_out1       (rf_out1),
        .rf_out2       (rf_out2),
        .done          (done),
        .result        (result)
`ifdef SEQ_FLAGS_EN
        ,
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag)
`endif
    );

    // Behavioural 4-entry register file: combinational read, clocked write, no reset.
    logic [WIDTH-1:0] rf_mem [4] = '{default: '0};
    assign rf_out1 = rf_mem[rf_addr_out1];
    assign rf_out2 = rf_mem[rf_addr_out2];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr_input] <= rf_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one instruction: {carry, value}.
    function automatic logic [WIDTH:0] calc(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] imm);
        int unsigned mod = 1 << WIDTH;
        int unsigned s;
        logic [WIDTH-1:0] v;
        logic c;
        c = 1'b0;
        case (op)
            3'd0: begin s = a + b;   v = WIDTH'(s % mod); c = (s >= mod); end
            3'd1: begin v = WIDTH'((int'(a) - int'(b) + int'(mod)) % int'(mod)); c = (a < b); end
            3'd2: v = a & b;
            3'd3: v = a | b;
            3'd4: v = a ^ b;
            3'd5: v = imm;
            3'd6: begin s = a + imm; v = WIDTH'(s % mod); c = (s >= mod); end
            default: v = a;
        endcase
        return {c, v};
    endfunction

    // Timeline model: an accepted instruction occupies 3 further cycles, writing in the last.
    int               m_cnt = 0;
    logic [1:0]       m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    logic [WIDTH:0]   m_val = '0;
    logic [WIDTH-1:0] m_result = '0;
    logic             m_zero = 1'b0, m_carry = 1'b0;
    logic [WIDTH-1:0] m_rf [4] = '{default: '0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_rd <= '0; m_rs1 <= '0; m_rs2 <= '0;
            m_result <= '0; m_zero <= 1'b0; m_carry <= 1'b0;
        end else if (m_cnt == 0) begin
            if (instr_valid) begin
                m_cnt <= 3;
                m_rd  <= instr_rd; m_rs1 <= instr_rs1; m_rs2 <= instr_rs2;
                m_val <= calc(instr_op, m_rf[instr_rs1], m_rf[instr_rs2], instr_imm);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_result <= m_val[WIDTH-1:0];
                m_zero   <= (m_val[WIDTH-1:0] == '0);
                m_carry  <= m_val[WIDTH];
            end
            if (m_cnt == 1) m_rf[m_rd] <= m_val[WIDTH-1:0];
        end
    end

    int cyc = 0;
    int dut_acc = 0;
    int acc_cyc [16];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && instr_valid && instr_ready) begin
            if (dut_acc < 16) acc_cyc[dut_acc] <= cyc;
            dut_acc <= dut_acc + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("instr_ready", 32'(instr_ready), 32'(m_cnt == 0));
            check("rf_we", 32'(rf_we), 32'(m_cnt == 1));
            check("done", 32'(done), 32'(m_cnt == 1));
            check("rf_addr_out1", 32'(rf_addr_out1), 32'(m_rs1));
            check("rf_addr_out2", 32'(rf_addr_out2), 32'(m_rs2));
            check("result", 32'(result), 32'(m_result));
            if (m_cnt == 1) begin
                check("rf_addr_input", 32'(rf_addr_input), 32'(m_rd));
                check("rf_data", 32'(rf_data), 32'(m_val[WIDTH-1:0]));
            end
`ifdef SEQ_FLAGS_EN
            check("zero_flag", 32'(zero_flag), 32'(m_zero));
            check("carry_flag", 32'(carry_flag), 32'(m_carry));
`endif
            for (int i = 0; i < 4; i++) check("regfile", 32'(rf_mem[i]), 32'(m_rf[i]));
        end
    end

    // Called just after an edge while idle; returns just after the write-back edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [WIDTH-1:0] imm);
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " instr_ready"}, 32'(instr_ready), 32'd1);
        check({tag, " rf_we"}, 32'(rf_we), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " addr_in"}, 32'(rf_addr_input), 32'd0);
        check({tag, " addr_out1"}, 32'(rf_addr_out1), 32'd0);
        check({tag, " addr_out2"}, 32'(rf_addr_out2), 32'd0);
        check({tag, " rf_data"}, 32'(rf_data), 32'd0);
        check({tag, " result"}, 32'(result), 32'd0);
`ifdef SEQ_FLAGS_EN
        check({tag, " zero_flag"}, 32'(zero_flag), 32'd0);
        check({tag, " carry_flag"}, 32'(carry_flag), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b0;

        issue(3'd5, 2'd1, 2'd0, 2'd0, 8'h05);           // LDI r1,0x05
        check("ldi r1", 32'(rf_mem[1]), 32'h05);
        issue(3'd5, 2'd2, 2'd1, 2'd2, 8'h03);           // LDI r2,0x03
        check("ldi r2", 32'(rf_mem[2]), 32'h03);
        issue(3'd0, 2'd3, 2'd1, 2'd2, 8'h00);           // ADD r3,r1,r2
        check("add result", 32'(result), 32'h08);
        check("add r3", 32'(rf_mem[3]), 32'h08);
        issue(3'd1, 2'd0, 2'd2, 2'd1, 8'h00);           // SUB r0,r2,r1
        check("sub result", 32'(result), 32'hFE);
        check("sub r0", 32'(rf_mem[0]), 32'hFE);
`ifdef SEQ_FLAGS_EN
        check("sub borrow", 32'(carry_flag), 32'd1);
`endif

        // Reset while the sequencer sits in READ.
        instr_op = 3'd5; instr_rd = 2'd1; instr_rs1 = 2'd2; instr_rs2 = 2'd3; instr_imm = 8'hAA;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid-read");
        @(posedge clk); #1;
        check("mid-read rf_we", 32'(rf_we), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid-read no write r1", 32'(rf_mem[1]), 32'h05);

        issue(3'd5, 2'd1, 2'd0, 2'd0, 8'h80);           // LDI r1,0x80
        issue(3'd0, 2'd1, 2'd1, 2'd1, 8'h00);           // ADD r1,r1,r1
        check("add wrap r1", 32'(rf_mem[1]), 32'h00);
`ifdef SEQ_FLAGS_EN
        check("add wrap zero", 32'(zero_flag), 32'd1);
        check("add wrap carry", 32'(carry_flag), 32'd1);
`endif

        // instr_valid held high across three instructions, four cycles each.
        base = dut_acc;
        instr_valid = 1'b1;
        instr_op = 3'd5; instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 8'h11;
        repeat (4) @(posedge clk);
        #1;
        instr_op = 3'd6; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 8'h22;
        repeat (4) @(posedge clk);
        #1;
        instr_op = 3'd3; instr_rd = 2'd3; instr_rs1 = 2'd2; instr_rs2 = 2'd0; instr_imm = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stream accepts", 32'(dut_acc - base), 32'd3);
        check("stream spacing 1", 32'(acc_cyc[base+1] - acc_cyc[base]), 32'd4);
        check("stream spacing 2", 32'(acc_cyc[base+2] - acc_cyc[base+1]), 32'd4);
        check("stream r0", 32'(rf_mem[0]), 32'h11);
        check("stream r2", 32'(rf_mem[2]), 32'h33);
        check("stream r3", 32'(rf_mem[3]), 32'h33);

        issue(3'd4, 2'd2, 2'd2, 2'd2, 8'h00);           // XOR r2,r2,r2
        check("xor r2", 32'(rf_mem[2]), 32'h00);
        issue(3'd7, 2'd3, 2'd2, 2'd0, 8'h00);           // MOV r3,r2
        check("mov r3", 32'(rf_mem[3]), 32'h00);
`ifdef SEQ_FLAGS_EN
        check("mov zero", 32'(zero_flag), 32'd1);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
